// File: rtl/slot_scheduler.sv
// slot_scheduler: steps slots 0..3 and runs HIT/GND pairs, hush and an ADC window in each; `define SLOT_SKIP_EN adds i_slot_en
module slot_scheduler #(
    parameter int TW       = 16,
    parameter int MIN_SLOT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_run,
    input  logic [TW-1:0] i_ts_time_0,
    input  logic [TW-1:0] i_ts_time_1,
    input  logic [TW-1:0] i_ts_time_2,
    input  logic [TW-1:0] i_ts_time_3,
    input  logic [3:0]    i_pulse_mask,
    input  logic [7:0]    i_pulse_hit,
    input  logic [7:0]    i_pulse_gnd,
    input  logic [3:0]    i_pulse_count,
    input  logic [TW-1:0] i_pulse_hush,
`ifdef SLOT_SKIP_EN
    input  logic [3:0]    i_slot_en,
`endif
    output logic [1:0]    o_slot,
    output logic          o_slot_start,
    output logic          o_frame_start,
    output logic [3:0]    o_pulse_p,
    output logic [3:0]    o_pulse_n,
    output logic          o_hush,
    output logic          o_adc_en,
    output logic          o_overrun
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] HIT  = 3'd2;
    localparam logic [2:0] GND  = 3'd3;
    localparam logic [2:0] HUSH = 3'd4;
    localparam logic [2:0] ACQ  = 3'd5;
    localparam logic [2:0] WAIT = 3'd6;
    localparam logic [TW-1:0] MIN_T = TW'(MIN_SLOT);
    localparam logic [TW-1:0] ONE   = TW'(1);
    localparam logic [TW-1:0] TWO   = TW'(2);

    logic [2:0]    state, state_nx;
    logic [1:0]    slot_nx;
    logic [TW-1:0] rem, rem_nx, pc, pc_nx, hush, hush_nx, ts_sel, t_len;
    logic [7:0]    hit, hit_nx, gnd, gnd_nx;
    logic [3:0]    mask, mask_nx, pairs, pairs_nx;
    logic          slot_en, last, pair_done;

`ifdef SLOT_SKIP_EN
    assign slot_en = i_slot_en[o_slot];
`else
    assign slot_en = 1'b1;
`endif

    assign ts_sel = o_slot == 2'd0 ? i_ts_time_0 :
                    o_slot == 2'd1 ? i_ts_time_1 :
                    o_slot == 2'd2 ? i_ts_time_2 : i_ts_time_3;
    assign t_len  = ts_sel < MIN_T ? MIN_T : ts_sel;
    // rem counts cycles left after the current one; it is loaded at LOAD, so LOAD itself is never last
    assign last   = state != IDLE && state != LOAD && rem == '0;

    // Phase sequencing inside a slot; the slot timer overrides everything on the final cycle
    always_comb begin
        state_nx  = state;
        slot_nx   = o_slot;
        rem_nx    = rem;
        pc_nx     = pc;
        pairs_nx  = pairs;
        mask_nx   = mask;
        hit_nx    = hit;
        gnd_nx    = gnd;
        hush_nx   = hush;
        pair_done = 1'b0;
        case (state)
            IDLE: state_nx = i_run ? LOAD : IDLE;
            LOAD: begin
                mask_nx  = i_pulse_mask;
                hit_nx   = i_pulse_hit;
                gnd_nx   = i_pulse_gnd;
                hush_nx  = i_pulse_hush;
                pairs_nx = i_pulse_count;
                rem_nx   = t_len - TWO;
                if (!slot_en) begin
                    state_nx = WAIT;
                end else if (i_pulse_count != '0 && i_pulse_hit != '0) begin
                    state_nx = HIT;
                    pc_nx    = TW'(i_pulse_hit) - ONE;
                end else if (i_pulse_count != '0 && i_pulse_gnd != '0) begin
                    state_nx = GND;
                    pc_nx    = TW'(i_pulse_gnd) - ONE;
                end else if (i_pulse_hush != '0) begin
                    state_nx = HUSH;
                    pc_nx    = i_pulse_hush - ONE;
                end else begin
                    state_nx = ACQ;
                end
            end
            HIT: begin
                if (pc != '0) begin
                    pc_nx = pc - ONE;
                end else if (gnd != '0) begin
                    state_nx = GND;
                    pc_nx    = TW'(gnd) - ONE;
                end else begin
                    pair_done = 1'b1;
                end
            end
            GND: begin
                if (pc != '0) pc_nx = pc - ONE;
                else pair_done = 1'b1;
            end
            HUSH: begin
                if (pc != '0) pc_nx = pc - ONE;
                else state_nx = ACQ;
            end
            default: ;
        endcase
        if (pair_done) begin
            pairs_nx = pairs - 4'd1;
            if (pairs != 4'd1) begin
                state_nx = hit != '0 ? HIT : GND;
                pc_nx    = hit != '0 ? TW'(hit) - ONE : TW'(gnd) - ONE;
            end else if (hush != '0) begin
                state_nx = HUSH;
                pc_nx    = hush - ONE;
            end else begin
                state_nx = ACQ;
            end
        end
        if (state != IDLE && state != LOAD) rem_nx = rem - ONE;
        if (last) begin
            state_nx = i_run ? LOAD : IDLE;
            slot_nx  = i_run ? o_slot + 2'd1 : 2'd0;
            rem_nx   = '0;
        end
    end

    // State, timers and outputs registered together so outputs align with the state they decode
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rem           <= '0;
            pc            <= '0;
            pairs         <= '0;
            mask          <= '0;
            hit           <= '0;
            gnd           <= '0;
            hush          <= '0;
            o_slot        <= '0;
            o_slot_start  <= 1'b0;
            o_frame_start <= 1'b0;
            o_pulse_p     <= '0;
            o_pulse_n     <= '0;
            o_hush        <= 1'b0;
            o_adc_en      <= 1'b0;
            o_overrun     <= 1'b0;
        end else begin
            state         <= state_nx;
            rem           <= rem_nx;
            pc            <= pc_nx;
            pairs         <= pairs_nx;
            mask          <= mask_nx;
            hit           <= hit_nx;
            gnd           <= gnd_nx;
            hush          <= hush_nx;
            o_slot        <= slot_nx;
            o_slot_start  <= state_nx == LOAD;
            o_frame_start <= state_nx == LOAD && slot_nx == 2'd0;
            o_pulse_p     <= state_nx == HIT ? mask_nx : 4'd0;
            o_pulse_n     <= state_nx == GND ? mask_nx : 4'd0;
            o_hush        <= state_nx == HUSH;
            o_adc_en      <= state_nx == ACQ;
            o_overrun     <= (state_nx == HIT || state_nx == GND || state_nx == HUSH) && rem_nx == '0;
        end
    end
endmodule
